// File: rtl/inst_fetch_if.sv
// Fetch-stage bus bundle: PC handshake, byte-wide instruction memory port,
// flush input and the one-entry output buffer towards decode.
interface inst_fetch_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] pc_i;
  logic                  ce_i;
  logic                  pc_stall_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic                  mem_rd_o;
  logic [7:0]            mem_din_i;
  logic                  flush_i;
  logic [31:0]           inst_o;
  logic [ADDR_WIDTH-1:0] inst_pc_o;
  logic                  inst_misalign_o;
  logic                  inst_valid_o;
  logic                  id_ready_i;

  // The fetch block itself
  modport slave (
    input  pc_i, ce_i, mem_din_i, flush_i, id_ready_i,
    output pc_stall_o, mem_addr_o, mem_rd_o,
           inst_o, inst_pc_o, inst_misalign_o, inst_valid_o
  );

  // PC stage, memory and decode side
  modport master (
    output pc_i, ce_i, mem_din_i, flush_i, id_ready_i,
    input  pc_stall_o, mem_addr_o, mem_rd_o,
           inst_o, inst_pc_o, inst_misalign_o, inst_valid_o
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: reads a 32-bit instruction one byte per cycle over
// an 8-bit memory port, assembles it little-endian and holds it in a
// one-entry buffer until decode takes it. Misaligned PCs skip memory and
// produce a flagged zero instruction.
module inst_fetch #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  inst_fetch_if.slave bus
);

  typedef enum logic [2:0] {IDLE, B0, B1, B2, B3, LAST} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            byte0, byte1, byte2;
  logic                  accept;
  logic                  aligned;
  logic                  strobe;

  logic [31:0]           inst_q;
  logic [ADDR_WIDTH-1:0] inst_pc_q;
  logic                  misalign_q;
  logic                  valid_q;

  // Accept decision, read strobe and next-state selection
  always_comb begin
    accept    = (state == IDLE) && bus.ce_i && !bus.flush_i &&
                (!valid_q || bus.id_ready_i);
    aligned   = (bus.pc_i[1:0] == 2'b00);
    strobe    = (state == B0) || (state == B1) || (state == B2) || (state == B3);
    state_nxt = state;
    if (bus.flush_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept && aligned) state_nxt = B0;
        B0:      state_nxt = B1;
        B1:      state_nxt = B2;
        B2:      state_nxt = B3;
        B3:      state_nxt = LAST;
        LAST:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Fetch address and memory address; the memory address is a running
  // pointer so it naturally holds its last value once the strobes stop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= '0;
      addr_q   <= '0;
    end else if (accept && aligned) begin
      fetch_pc <= bus.pc_i;
      addr_q   <= bus.pc_i;
    end else if (!bus.flush_i && (state == B0 || state == B1 || state == B2)) begin
      addr_q   <= addr_q + ADDR_WIDTH'(1);
    end
  end

  // Capture the bytes returning one cycle after each strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte0 <= '0;
      byte1 <= '0;
      byte2 <= '0;
    end else begin
      case (state)
        B1:      byte0 <= bus.mem_din_i;
        B2:      byte1 <= bus.mem_din_i;
        B3:      byte2 <= bus.mem_din_i;
        default: ;
      endcase
    end
  end

  // Output buffer: flush clears, completed or misaligned fetch loads,
  // decode consumption releases
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_q     <= '0;
      inst_pc_q  <= '0;
      misalign_q <= 1'b0;
      valid_q    <= 1'b0;
    end else if (bus.flush_i) begin
      misalign_q <= 1'b0;
      valid_q    <= 1'b0;
    end else if (state == LAST) begin
      inst_q     <= {bus.mem_din_i, byte2, byte1, byte0};
      inst_pc_q  <= fetch_pc;
      misalign_q <= 1'b0;
      valid_q    <= 1'b1;
    end else if (accept && !aligned) begin
      inst_q     <= '0;
      inst_pc_q  <= bus.pc_i;
      misalign_q <= 1'b1;
      valid_q    <= 1'b1;
    end else if (bus.id_ready_i) begin
      valid_q    <= 1'b0;
    end
  end

  // Drive the bus outputs
  always_comb begin
    bus.pc_stall_o      = !accept;
    bus.mem_rd_o        = strobe;
    bus.mem_addr_o      = addr_q;
    bus.inst_o          = inst_q;
    bus.inst_pc_o       = inst_pc_q;
    bus.inst_misalign_o = misalign_q;
    bus.inst_valid_o    = valid_q;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage between `pc_reg` and the IF/ID pipeline register. It accepts a fetch address from the PC stage and reads the instruction over the 8-bit instruction-memory port, one byte per cycle. It assembles the four bytes little-endian into a 32-bit word and holds it in a one-entry output buffer until the decode stage accepts it. It back-pressures the PC stage while busy and discards in-flight work on a pipeline flush.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, width of the fetch address and memory address.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `pc_i`  in  ADDR_WIDTH  fetch address from the PC stage.
- `ce_i`  in  1  PC stage enable; `pc_i` is valid when high.
- `pc_stall_o`  out  1  high when this block does not accept `pc_i` this cycle.
- `mem_addr_o`  out  ADDR_WIDTH  byte address to instruction memory.
- `mem_rd_o`  out  1  read strobe.
- `mem_din_i`  in  8  read data, valid exactly one cycle after the strobe.
- `flush_i`  in  1  synchronous flush from branch resolution.
- `inst_o`  out  32  assembled instruction.
- `inst_pc_o`  out  ADDR_WIDTH  address of `inst_o`.
- `inst_misalign_o`  out  1  `inst_pc_o[1:0]` was nonzero; `inst_o` is 0.
- `inst_valid_o`  out  1  output buffer holds an instruction.
- `id_ready_i`  in  1  decode consumes the buffer this cycle.

## Operation
- FSM states: IDLE, B0, B1, B2, B3, LAST.
- Accept condition: state IDLE, `ce_i`=1, `flush_i`=0, and (`inst_valid_o`=0 or `id_ready_i`=1).
- `pc_stall_o` = NOT accept condition, computed combinationally.
- On an aligned accept (`pc_i[1:0]`=0), latch `pc_i` into `fetch_pc` and go IDLE→B0.
- B0..B3 (one cycle each): `mem_rd_o`=1 and `mem_addr_o`=`fetch_pc`+k for k=0..3. The sum is modulo 2^ADDR_WIDTH, so it wraps at the top of the address space.
- Byte capture: in B1, B2 and B3, capture `mem_din_i` as byte k-1. In LAST, capture byte 3.
- LAST→IDLE, loading the buffer: `inst_o`={b3,b2,b1,b0}, `inst_pc_o`=`fetch_pc`, `inst_misalign_o`=0, `inst_valid_o`=1.
- Misaligned accept (`pc_i[1:0]`≠0): no memory access and no state change. The buffer loads on the next edge with `inst_o`=0, `inst_pc_o`=`pc_i`, `inst_misalign_o`=1, `inst_valid_o`=1.
- Buffer release: `inst_valid_o` clears when `id_ready_i`=1, unless it is reloaded on the same edge. A buffer load and a decode consume on the same edge are legal. This only occurs for a misaligned accept, because an aligned fetch reaches LAST at least 5 cycles after its accept.
- `id_ready_i` is ignored while `inst_valid_o`=0.
- `ce_i`=0 in IDLE: no accept; stay IDLE.
- Flush (`flush_i`=1) has the highest priority:
  - go to IDLE and clear `inst_valid_o` and `inst_misalign_o`;
  - `mem_rd_o` is 0 on the following cycle;
  - the byte returning after a flushed strobe is ignored;
  - no accept occurs in the flush cycle.
- `mem_rd_o`=0 and `mem_addr_o` holds its last value outside B0..B3.

## Timing
- Reset values (asynchronous, while `rst`=0): state IDLE, `mem_rd_o`=0, `mem_addr_o`=0, `inst_o`=0, `inst_pc_o`=0, `inst_misalign_o`=0, `inst_valid_o`=0. `pc_stall_o` follows its combinational equation.
- Reset release mid-fetch restarts in IDLE with no residual read.
- Aligned latency: accept at edge A. Strobes in cycles A+1..A+4, data returns A+2..A+5, `inst_valid_o` is high from A+6.
- Back-to-back aligned fetches: the next accept is possible in the cycle after LAST, provided the buffer is free or being consumed. Peak throughput is 1 instruction per 6 cycles.
- Misaligned latency: `inst_valid_o` is high 1 cycle after the accept.
- `pc_stall_o` is high in B0..LAST and while a held buffer is not consumed.

## Test plan
- Reset, then `pc_i`=0x0, `ce_i`=1, memory bytes 0x13,0x05,0x10,0x00 → strobes at addresses 0,1,2,3 on consecutive cycles; `inst_o`=0x00100513, `inst_pc_o`=0 and `inst_valid_o`=1 exactly 6 cycles after the accept.
- `id_ready_i` held 0 for 10 cycles after valid → `inst_o` stable and `pc_stall_o`=1 throughout. Raising `id_ready_i` for 1 cycle consumes the buffer, and the next fetch is accepted in that same cycle.
- `flush_i` pulsed in B2 of a fetch from 0x100 → `mem_rd_o` is 0 from the next cycle, `inst_valid_o` stays 0, and a new accept of 0x200 produces `inst_pc_o`=0x200 with the correct data.
- `pc_i`=0x6 → no `mem_rd_o`; next cycle `inst_valid_o`=1, `inst_misalign_o`=1, `inst_o`=0, `inst_pc_o`=0x6.
- `pc_i`=0xFFFFFFFC → strobe addresses 0xFFFFFFFC..0xFFFFFFFF with no carry out; correct instruction assembled.
- `rst` asserted low during B1 → all outputs reach reset values immediately (before the next clock edge); after release, a fresh accept of 0x0 completes normally.
